mv_select: RTL and testbench

MV_SELECT -- requirements
Module: mv_select

---
 rtl/mv_pkg.sv | 21 ++
 rtl/mv_select.sv | 119 +++++++++++
 tb/tb_mv_select.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mv_pkg.sv
// Shared widths, in_word field positions and FSM state type for mv_select.
package mv_pkg;

   localparam int unsigned SAD_W  = 12;
   localparam int unsigned MV_W   = 4;
   localparam int unsigned WORD_W = SAD_W + 2 * MV_W;

   localparam int unsigned SAD_LSB = 8;
   localparam int unsigned X_LSB   = 4;
   localparam int unsigned Y_LSB   = 0;

   localparam logic [WORD_W-1:0] IDLE_WORD = 20'hFFF00;
   localparam logic [SAD_W-1:0]  SAD_MAX   = 12'hFFF;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } state_t;

endpackage

// File: rtl/mv_select.sv
// Motion-vector selector: keeps the minimum-SAD row-best word over ROWS words.
// Define MV_SELECT_SEQ_CHECK_EN to flag y-field / row-counter mismatches on err.
module mv_select
   import mv_pkg::*;
#(
   parameter int unsigned ROWS   = 16,
   parameter int unsigned CENTER = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SAD_W-1:0]  best_sad,
   output logic [MV_W:0]     mv_dx,
   output logic [MV_W:0]     mv_dy,
   output logic              busy,
   output logic              err
);

   localparam int unsigned    RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [MV_W:0] CenterV = (MV_W + 1)'(CENTER);

   state_t           r_state;
   state_t           w_state_next;
   logic [SAD_W-1:0] r_best_sad;
   logic [MV_W-1:0]  r_best_x;
   logic [MV_W-1:0]  r_best_y;
   logic [RowW-1:0]  r_row;

   logic [SAD_W-1:0] w_sad;
   logic [MV_W-1:0]  w_x;
   logic [MV_W-1:0]  w_y;
   logic             w_open;
   logic             w_accept;
   logic             w_last;
   logic             w_take;

   assign w_sad = in_word[SAD_LSB +: SAD_W];
   assign w_x   = in_word[X_LSB +: MV_W];
   assign w_y   = in_word[Y_LSB +: MV_W];

   assign w_open   = (r_state == StIdle) && start;
   assign w_accept = (r_state == StAccum) && in_valid;
   assign w_last   = (32'(r_row) == ROWS - 1);
   // Row 0 always wins so an all-FFF search still reports a real position.
   assign w_take   = w_accept && ((r_row == '0) || (w_sad < r_best_sad));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) w_state_next = StAccum;
         end
         StAccum: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (w_accept && w_last) w_state_next = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || w_open) begin
         r_best_sad <= SAD_MAX;
         r_best_x   <= '0;
         r_best_y   <= '0;
         r_row      <= '0;
      end else if (w_accept) begin
         r_row <= w_last ? '0 : r_row + RowW'(1);
         if (w_take) begin
            r_best_sad <= w_sad;
            r_best_x   <= w_x;
            r_best_y   <= w_y;
         end
      end
   end

`ifdef MV_SELECT_SEQ_CHECK_EN
   logic r_err;

   always_ff @(posedge clk) begin
      if (!rst_n || w_open) begin
         r_err <= 1'b0;
      end else if (w_accept && (32'(w_y) != 32'(r_row))) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign best_sad = r_best_sad;
   assign mv_dx    = {1'b0, r_best_x} - CenterV;
   assign mv_dy    = {1'b0, r_best_y} - CenterV;

endmodule

// File: tb/tb_mv_select.sv
// Self-checking bench for mv_select: queue-based reference model plus directed scenarios.
module tb_mv_select;

   localparam int ROWS   = 16;
   localparam int CENTER = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start     = 1'b0;
   logic [19:0] in_word   = 20'hFFF00;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [11:0] best_sad;
   logic [4:0]  mv_dx;
   logic [4:0]  mv_dy;
   logic        busy;
   logic        err;

   mv_select #(.ROWS(ROWS), .CENTER(CENTER)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_word   (in_word),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .best_sad  (best_sad),
      .mv_dx     (mv_dx),
      .mv_dy     (mv_dy),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase plus the list of words accepted in the current search.
   int          m_mode = 0;  // 0 waiting, 1 collecting, 2 holding result
   logic [19:0] m_q[$];
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode = 0;
         m_q.delete();
      end else begin
         case (m_mode)
            0: if (start) begin
               m_mode = 1;
               m_q.delete();
            end
            1: if (in_valid) begin
               m_q.push_back(in_word);
               if (m_q.size() == ROWS) m_mode = 2;
            end
            default: if (out_ready) m_mode = 0;
         endcase
      end
   end

   function automatic void model_result(output logic [11:0] sad, output logic [4:0] dx,
                                        output logic [4:0] dy, output logic e);
      int          bi = -1;
      logic [19:0] w;
      logic [19:0] b;
      int          x = 0;
      int          y = 0;
      e = 1'b0;
      for (int i = 0; i < m_q.size(); i++) begin
         w = m_q[i];
         if (bi >= 0) b = m_q[bi];
         if (bi < 0 || w[19:8] < b[19:8]) bi = i;
         if (int'(w[3:0]) != i) e = 1'b1;
      end
`ifndef MV_SELECT_SEQ_CHECK_EN
      e = 1'b0;
`endif
      sad = 12'hFFF;
      if (bi >= 0) begin
         b   = m_q[bi];
         sad = b[19:8];
         x   = int'(b[7:4]);
         y   = int'(b[3:0]);
      end
      dx = 5'(x - CENTER);
      dy = 5'(y - CENTER);
   endfunction

   always @(negedge clk) begin
      logic [11:0] e_sad;
      logic [4:0]  e_dx;
      logic [4:0]  e_dy;
      logic        e_err;
      if (chk_en) begin
         model_result(e_sad, e_dx, e_dy, e_err);
         check("out_valid", 32'(out_valid), 32'(m_mode == 2));
         check("in_ready",  32'(in_ready),  32'(m_mode == 1));
         check("busy",      32'(busy),      32'(m_mode != 0));
         check("best_sad",  32'(best_sad),  32'(e_sad));
         check("mv_dx",     32'(mv_dx),     32'(e_dx));
         check("mv_dy",     32'(mv_dy),     32'(e_dy));
         check("err",       32'(err),       32'(e_err));
      end
   end

   logic [11:0] sads[ROWS];
   logic [3:0]  xs[ROWS];
   logic [3:0]  ys[ROWS];

   task automatic fill(input logic [11:0] base);
      for (int r = 0; r < ROWS; r++) begin
         sads[r] = base;
         xs[r]   = 4'd8;
         ys[r]   = 4'(r);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic feed(input int n, input int gap);
      for (int r = 0; r < n; r++) begin
         in_valid = 1'b1;
         in_word  = {sads[r], xs[r], ys[r]};
         step();
         in_valid = 1'b0;
         in_word  = 20'hFFF00;
         repeat (gap) step();
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) step();
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst busy",      32'(busy),      32'h0);
      check("rst best_sad",  32'(best_sad),  32'hFFF);
      check("rst mv_dx",     32'(mv_dx),     32'h18);
      check("rst err",       32'(err),       32'h0);

      // Idle words outside ACCUM
      step();
      in_valid = 1'b1;
      in_word  = 20'hFFF00;
      repeat (3) step();
      in_valid = 1'b0;
      @(negedge clk);
      check("idle busy",     32'(busy),     32'h0);
      check("idle best_sad", 32'(best_sad), 32'hFFF);
      step();

      // Basic
      fill(12'd100);
      sads[5] = 12'd20;
      xs[5]   = 4'd3;
      pulse_start();
      feed(ROWS, 0);
      @(negedge clk);
      check("basic out_valid", 32'(out_valid), 32'h1);
      check("basic best_sad",  32'(best_sad),  32'd20);
      check("basic mv_dx",     32'(mv_dx),     32'h1B);
      check("basic mv_dy",     32'(mv_dy),     32'h1D);

      // Backpressure: stray start and words while holding the result
      step();
      for (int c = 0; c < 10; c++) begin
         start    = (c == 3);
         in_valid = 1'b1;
         in_word  = {12'd0, 4'd1, 4'd1};
         step();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_word  = 20'hFFF00;
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'h1);
      check("bp in_ready",  32'(in_ready),  32'h0);
      check("bp best_sad",  32'(best_sad),  32'd20);
      check("bp mv_dx",     32'(mv_dx),     32'h1B);
      step();
      start = 1'b1;
      release_result();
      start = 1'b0;
      @(negedge clk);
      check("bp idle out_valid", 32'(out_valid), 32'h0);
      check("bp idle busy",      32'(busy),      32'h0);
      step();

      // Tie keeps earlier row
      fill(12'd50);
      sads[2] = 12'd7;
      sads[9] = 12'd7;
      xs[9]   = 4'd1;
      pulse_start();
      feed(ROWS, 0);
      @(negedge clk);
      check("tie best_sad", 32'(best_sad), 32'd7);
      check("tie mv_dy",    32'(mv_dy),    32'h1A);
      check("tie mv_dx",    32'(mv_dx),    32'h0);
      step();
      release_result();

      // Gaps between words
      fill(12'd100);
      sads[5] = 12'd20;
      xs[5]   = 4'd3;
      pulse_start();
      feed(ROWS, 1);
      @(negedge clk);
      check("gap out_valid", 32'(out_valid), 32'h1);
      check("gap best_sad",  32'(best_sad),  32'd20);
      check("gap mv_dx",     32'(mv_dx),     32'h1B);
      check("gap mv_dy",     32'(mv_dy),     32'h1D);
      step();
      release_result();

      // First word wins even at SAD FFF
      fill(12'hFFF);
      xs[0] = 4'd5;
      pulse_start();
      feed(ROWS, 0);
      @(negedge clk);
      check("fff best_sad", 32'(best_sad), 32'hFFF);
      check("fff mv_dx",    32'(mv_dx),    32'h1D);
      check("fff mv_dy",    32'(mv_dy),    32'h18);
      step();
      release_result();

      // Reset mid-search
      fill(12'd100);
      sads[2] = 12'd1;
      pulse_start();
      feed(7, 0);
      @(negedge clk);
      check("mid busy",     32'(busy),     32'h1);
      check("mid best_sad", 32'(best_sad), 32'd1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid rst busy",     32'(busy),     32'h0);
      check("mid rst best_sad", 32'(best_sad), 32'hFFF);
      repeat (3) step();
      @(negedge clk);
      check("mid rst out_valid", 32'(out_valid), 32'h0);
      step();

      // Sequence error on row 3
      fill(12'd100);
      sads[5] = 12'd20;
      xs[5]   = 4'd3;
      ys[3]   = 4'd7;
      pulse_start();
      feed(ROWS, 0);
      @(negedge clk);
      check("seq best_sad", 32'(best_sad), 32'd20);
`ifdef MV_SELECT_SEQ_CHECK_EN
      check("seq err", 32'(err), 32'h1);
`else
      check("seq err", 32'(err), 32'h0);
`endif
      step();
      release_result();
      pulse_start();
      @(negedge clk);
      check("seq clr err",  32'(err),  32'h0);
      check("seq clr busy", 32'(busy), 32'h1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
